module_spi_arbiter: RTL
=======================

// Module: module_spi_arbiter
// PURPOSE
//  Shares one SPI master core between N_REQ requesters (e.g. UART bridge, sensor poller, test port).
//  Round-robin grants one requester, writes its command into the core's control register with send=1,
//  tracks the core's busy flag until the burst completes, then clears send and reports done/error.
//  Sits between the requester modules and the SPI core's control-register write port.
// PARAMETERS
//  N_REQ       4    number of requesters, 2..8
//  START_TO    16   max clk_i cycles from the control write until spi_busy_i must rise, else error
// PORTS
//  clk_i         in   1                   system clock, all logic on rising edge
//  rst_i         in   1                   synchronous, active-high reset
//  req_i         in   N_REQ               level request per requester; held until its done_o/err_o
//  cmd_i         in   N_REQ x spi_cmd_t   per-requester command (cs_ctrl, all_1s, all_0s, n_tx_end)
//  spi_busy_i    in   1                   SPI core busy (high from its LOAD state until FIN state)
//  gnt_o         out  N_REQ               one-hot grant, held for the whole burst
//  sel_o         out  $clog2(N_REQ)       binary index of the current grant (chip/route select)
//  busy_o        out  1                   arbiter not in IDLE
//  ctrl_we_o     out  1                   one-cycle write strobe into the SPI control register
//  ctrl_wdata_o  out  palabra_control     control word written on ctrl_we_o
//  done_o        out  N_REQ               one-cycle pulse to the granted requester on completion
//  err_o         out  N_REQ               one-cycle pulse to the granted requester on start timeout
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, gnt_o=0, sel_o=0, busy_o=0, ctrl_we_o=0, ctrl_wdata_o='0,
//   done_o=0, err_o=0, timeout counter=0. Reset mid-burst aborts immediately. No clear-send write
//   is issued; the core is reset from the same reset tree.
//  FSM (all outputs registered):
//   IDLE  : if |req_i, pick the first set req_i[k] searching k=rr_ptr, rr_ptr+1, ... mod N_REQ.
//           Latch g=k and cmd_i[g]; set gnt_o[g] and sel_o=g. Next state: LOAD.
//   LOAD  : ctrl_we_o=1 for exactly 1 cycle; ctrl_wdata_o = cmd of g with send=1.
//           Clear the timeout counter. Next state: START.
//   START : count cycles. If spi_busy_i=1, go to RUN.
//           Else if count==START_TO-1, go to ERR.
//   RUN   : wait for spi_busy_i=0, then go to DONE. There is no timeout here; n_tx_end bounds the burst.
//   DONE  : done_o[g]=1 for 1 cycle. ctrl_we_o=1 with ctrl_wdata_o = latched cmd, send=0.
//           gnt_o=0; rr_ptr = (g+1) mod N_REQ. Next state: IDLE.
//   ERR   : same as DONE, but pulses err_o[g] instead of done_o[g].
//  Latency: req_i rise seen in IDLE -> gnt_o next cycle -> ctrl_we_o the cycle after (2 clk).
//  Back-to-back: the earliest re-grant is the cycle after DONE/ERR (IDLE is one cycle minimum).
//  The latched command is frozen for the whole burst; cmd_i changes after grant are ignored.
//  A granted requester dropping req_i mid-burst: the burst still completes and done_o still pulses.
//  A request arriving while busy waits; it is never lost as long as req_i is held.
//  Simultaneous requests: the round-robin order from rr_ptr decides, so no requester starves.
//  A spi_busy_i glitch high in IDLE/DONE/ERR is ignored.
//  The same requester re-requesting during DONE is served only after every other pending requester.
// STRUCTURE
//  spi_pkg: add typedef spi_cmd_t {cs_ctrl, all_1s, all_0s, n_tx_end[9:0]}, the arb state enum,
//   and a packing function spi_cmd_t -> palabra_control (send bit as argument).
//  Sub-module module_rr_picker: combinational (req, rr_ptr) -> (valid, index), reusable elsewhere.
//  Top: FSM, grant/cmd registers, timeout counter, rr_ptr register.
// TESTING
//  1 single req_i[2], busy high 3 cyc after write, low after 40 -> gnt 0100, one write with send=1,
//    done_o[2] pulse, second write with send=0, rr_ptr=3.
//  2 req_i=1111 held, 4 bursts -> grant order 0,1,2,3 from rr_ptr=0; then 0 again; no repeats.
//  3 spi_busy_i never rises, START_TO=16 -> err_o[g] exactly 16 cyc after LOAD, send cleared, IDLE.
//  4 cmd_i[1] changed during RUN -> ctrl_wdata_o at DONE equals the originally latched cmd (send=0).
//  5 rst_i pulsed during RUN -> next cycle all outputs 0, IDLE; fresh req_i[3] granted normally.
//  6 req_i[0] dropped mid-RUN -> done_o[0] still pulses; a concurrent req_i[1] is granted right after.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the SPI arbiter: per-requester command, control-register
// word written into the SPI core, arbiter FSM states and the packing helper.
package spi_pkg;

    typedef struct packed {
        logic       cs_ctrl;
        logic       all_1s;
        logic       all_0s;
        logic [9:0] n_tx_end;
    } spi_cmd_t;

    typedef struct packed {
        logic       send;
        logic       cs_ctrl;
        logic       all_1s;
        logic       all_0s;
        logic [9:0] n_tx_end;
    } palabra_control;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } arb_state_e;

    function automatic palabra_control pack_ctrl(input spi_cmd_t c,
                                                 input logic send);
        palabra_control w;
        w.send     = send;
        w.cs_ctrl  = c.cs_ctrl;
        w.all_1s   = c.all_1s;
        w.all_0s   = c.all_0s;
        w.n_tx_end = c.n_tx_end;
        return w;
    endfunction

endpackage

// File: rtl/module_spi_arbiter_if.sv
// Requester/SPI-core side bundle of the arbiter.
// slave: arbiter view (requests, commands, core busy in; grants, strobes out).
// master: environment view (drives requests/commands/busy, observes the rest).
interface module_spi_arbiter_if #(
    parameter int N_REQ = 4
) ();
    import spi_pkg::*;

    localparam int SW = $clog2(N_REQ);

    logic [N_REQ-1:0]            req_i;
    spi_cmd_t [N_REQ-1:0]        cmd_i;
    logic                        spi_busy_i;
    logic [N_REQ-1:0]            gnt_o;
    logic [SW-1:0]               sel_o;
    logic                        busy_o;
    logic                        ctrl_we_o;
    palabra_control              ctrl_wdata_o;
    logic [N_REQ-1:0]            done_o;
    logic [N_REQ-1:0]            err_o;

    modport slave (
        input  req_i, cmd_i, spi_busy_i,
        output gnt_o, sel_o, busy_o, ctrl_we_o, ctrl_wdata_o, done_o, err_o
    );

    modport master (
        output req_i, cmd_i, spi_busy_i,
        input  gnt_o, sel_o, busy_o, ctrl_we_o, ctrl_wdata_o, done_o, err_o
    );
endinterface

// File: rtl/module_spi_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req_i bit searching from ptr_i
// upward modulo N. Ports: req_i, ptr_i in; valid_o, idx_o out.
module module_rr_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         valid_o,
    output logic [W-1:0] idx_o
);
    logic [W:0] s;

    assign valid_o = |req_i;

    // Scan from the farthest offset down so the nearest hit to ptr_i wins.
    always_comb begin
        idx_o = '0;
        s     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            s = {1'b0, ptr_i} + (W + 1)'(i);
            if (s >= (W + 1)'(N)) s = s - (W + 1)'(N);
            if (req_i[s[W-1:0]]) idx_o = s[W-1:0];
        end
    end
endmodule

// File: rtl/module_spi_arbiter.sv
// Round-robin sharing of one SPI master core between N_REQ requesters.
// Ports: clk_i, rst_i (sync, active-high), bus (slave side of the bundle).
module module_spi_arbiter
    import spi_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int START_TO = 16
) (
    input logic                 clk_i,
    input logic                 rst_i,
    module_spi_arbiter_if.slave bus
);
    localparam int SW = $clog2(N_REQ);
    localparam int CW = (START_TO > 1) ? $clog2(START_TO) : 1;

    arb_state_e     state_q, state_d;
    logic [SW-1:0]  g_q, g_d;
    logic [SW-1:0]  rr_q, rr_d;
    spi_cmd_t       cmd_q, cmd_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [N_REQ-1:0] err_q, err_d;
    logic           we_q, we_d;
    palabra_control wdata_q, wdata_d;

    logic           pick_valid;
    logic [SW-1:0]  pick_idx;

    module_rr_picker #(.N(N_REQ), .W(SW)) u_pick (
        .req_i   (bus.req_i),
        .ptr_i   (rr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        rr_d    = rr_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = '0;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    g_d     = pick_idx;
                    cmd_d   = bus.cmd_i[pick_idx];
                    gnt_d   = {{(N_REQ - 1){1'b0}}, 1'b1} << pick_idx;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                we_d    = 1'b1;
                wdata_d = pack_ctrl(cmd_q, 1'b1);
                cnt_d   = '0;
                state_d = ST_START;
            end
            ST_START: begin
                if (bus.spi_busy_i) begin
                    state_d = ST_RUN;
                end else if (cnt_q == CW'(START_TO - 1)) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!bus.spi_busy_i) state_d = ST_DONE;
            end
            ST_DONE, ST_ERR: begin
                if (state_q == ST_DONE) done_d = gnt_q;
                else                    err_d  = gnt_q;
                we_d    = 1'b1;
                wdata_d = pack_ctrl(cmd_q, 1'b0);
                gnt_d   = '0;
                // Move past the served requester so it goes to the back of the line.
                rr_d    = (g_q == SW'(N_REQ - 1)) ? '0 : g_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            g_q     <= '0;
            rr_q    <= '0;
            cmd_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            rr_q    <= rr_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.gnt_o        = gnt_q;
    assign bus.sel_o        = g_q;
    assign bus.busy_o       = (state_q != ST_IDLE);
    assign bus.ctrl_we_o    = we_q;
    assign bus.ctrl_wdata_o = wdata_q;
    assign bus.done_o       = done_q;
    assign bus.err_o        = err_q;
endmodule
